dmem_stall: RTL and testbench

- Parametrised, multi-cycle data memory for the MIPS core.
- Generalises the single-cycle data memory: configurable data width, depth and access latency, plus byte-enable writes and out-of-range detection.
- Drives a req/ready handshake and a stall signal so the core's pipeline freezes until each load or store completes.
- Sits between the core's memory stage and backing storage in the top-level system.

---
 rtl/dmem_stall.sv | 112 +++++++++++
 tb/tb_dmem_stall.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/dmem_stall.sv
// Multi-cycle data memory with req/ready handshake and pipeline stall.
// Each access waits LATENCY cycles, then takes effect when the FSM enters RESP.
module dmem_stall #(
  parameter int DATA_W  = 32,
  parameter int ADDR_W  = 8,
  parameter int LATENCY = 2
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                req,
  input  logic                write_en,
  input  logic [DATA_W/8-1:0] byte_en,
  input  logic [31:0]         addr,
  input  logic [DATA_W-1:0]   write_data,
  output logic [DATA_W-1:0]   read_data,
  output logic                ready,
  output logic                stall,
  output logic                err
);

  localparam int NB    = DATA_W / 8;
  localparam int B     = $clog2(NB);
  localparam int DEPTH = 1 << ADDR_W;
  localparam logic [7:0] LAT8 = 8'(LATENCY);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

  state_t              state;
  logic [7:0]          count;
  logic [31:0]         cap_addr;
  logic                cap_we;
  logic [NB-1:0]       cap_be;
  logic [DATA_W-1:0]   cap_wd;

  logic [DATA_W-1:0]   mem [DEPTH];

  logic [31:0]         acc_addr;
  logic                acc_we;
  logic [NB-1:0]       acc_be;
  logic [DATA_W-1:0]   acc_wd;
  logic [31:0]         word;
  logic [ADDR_W-1:0]   idx;
  logic                oor;
  logic                go_resp;

  // With LATENCY=0 the access happens on the accepting edge, so the live
  // inputs are used there; otherwise the captured copies are.
  always_comb begin
    acc_addr = (state == S_IDLE) ? addr       : cap_addr;
    acc_we   = (state == S_IDLE) ? write_en   : cap_we;
    acc_be   = (state == S_IDLE) ? byte_en    : cap_be;
    acc_wd   = (state == S_IDLE) ? write_data : cap_wd;
    word     = acc_addr >> B;
    idx      = word[ADDR_W-1:0];
    oor      = (word >> ADDR_W) != 32'd0;
    go_resp  = (state == S_IDLE && req && LATENCY == 0) ||
               (state == S_WAIT && count == 8'd1);
  end

  assign stall = req & ~ready & ~reset;

  // NOTE: all state below uses non-blocking assignments so every register
  // samples pre-edge values, independent of statement order.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= S_IDLE;
      count     <= 8'd0;
      ready     <= 1'b0;
      err       <= 1'b0;
      read_data <= '0;
      cap_addr  <= '0;
      cap_we    <= 1'b0;
      cap_be    <= '0;
      cap_wd    <= '0;
    end else begin
      ready <= go_resp;
      err   <= go_resp & oor;
      if (go_resp && !acc_we)
        read_data <= oor ? '0 : mem[idx];
      case (state)
        S_IDLE: begin
          if (req) begin
            cap_addr <= addr;
            cap_we   <= write_en;
            cap_be   <= byte_en;
            cap_wd   <= write_data;
            count    <= LAT8;
            state    <= (LATENCY == 0) ? S_RESP : S_WAIT;
          end
        end
        S_WAIT: begin
          count <= count - 8'd1;
          if (count == 8'd1)
            state <= S_RESP;
        end
        S_RESP:  state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

  // NOTE: the storage array has no reset; it keeps its contents across
  // reset, and the write is gated so a reset edge never commits a store.
  always_ff @(posedge clk) begin
    if (go_resp && acc_we && !oor && !reset) begin
      for (int i = 0; i < NB; i++)
        if (acc_be[i])
          mem[idx][8*i +: 8] <= acc_wd[8*i +: 8];
    end
  end

endmodule

// File: tb/tb_dmem_stall.sv
// Bench for dmem_stall: three instances (LATENCY 2, 0, 4) checked against a
// word-array reference model with directed and random accesses.
module tb_dmem_stall;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  logic [2:0]       req, we;
  logic [2:0][3:0]  be;
  logic [2:0][31:0] addr, wd;
  wire  [2:0][31:0] rd;
  wire  [2:0]       rdy, stl, er;

  int compared = 0;
  int mismatched = 0;

  // Reference model: one word array per instance plus the last load result.
  logic [31:0] mem_m [3][256];
  bit          wr_m  [3][256];
  logic [31:0] rd_m  [3];

  dmem_stall #(.DATA_W(32), .ADDR_W(8), .LATENCY(2)) u_l2 (
    .clk(clk), .reset(reset), .req(req[0]), .write_en(we[0]), .byte_en(be[0]),
    .addr(addr[0]), .write_data(wd[0]), .read_data(rd[0]), .ready(rdy[0]),
    .stall(stl[0]), .err(er[0]));

  dmem_stall #(.DATA_W(32), .ADDR_W(8), .LATENCY(0)) u_l0 (
    .clk(clk), .reset(reset), .req(req[1]), .write_en(we[1]), .byte_en(be[1]),
    .addr(addr[1]), .write_data(wd[1]), .read_data(rd[1]), .ready(rdy[1]),
    .stall(stl[1]), .err(er[1]));

  dmem_stall #(.DATA_W(32), .ADDR_W(8), .LATENCY(4)) u_l4 (
    .clk(clk), .reset(reset), .req(req[2]), .write_en(we[2]), .byte_en(be[2]),
    .addr(addr[2]), .write_data(wd[2]), .read_data(rd[2]), .ready(rdy[2]),
    .stall(stl[2]), .err(er[2]));

  function automatic int lat(input int d);
    return (d == 0) ? 2 : ((d == 1) ? 0 : 4);
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // One access on instance d. Accepted in the IDLE cycle where req is first
  // seen; ready must show exactly LATENCY+1 cycles later.
  task automatic access(input int d, input bit w, input logic [3:0] b,
                        input logic [31:0] a, input logic [31:0] data,
                        input int drop_at, input bit hold);
    int  l;
    int  k;
    int  idx;
    bit  oor;
    bit  got;
    l   = lat(d);
    oor = (a >> 10) != 0;
    idx = int'((a >> 2) & 32'hFF);
    @(negedge clk);
    req[d] = 1'b1; we[d] = w; be[d] = b; addr[d] = a; wd[d] = data;
    #1;
    check($sformatf("stall_accept_d%0d", d), {31'd0, stl[d]}, 32'd1);
    k = 0;
    got = 1'b0;
    while (!got && k < l + 8) begin
      @(negedge clk);
      k++;
      if (k == drop_at) req[d] = 1'b0;
      #1;
      if (rdy[d]) got = 1'b1;
      else begin
        check($sformatf("stall_wait_d%0d", d), {31'd0, stl[d]}, {31'd0, req[d]});
        check($sformatf("err_idle_d%0d", d), {31'd0, er[d]}, 32'd0);
      end
    end
    check($sformatf("ready_latency_d%0d", d), k, l + 1);
    if (got) begin
      if (w && !oor) begin
        for (int i = 0; i < 4; i++)
          if (b[i]) mem_m[d][idx][8*i +: 8] = data[8*i +: 8];
        if (b == 4'hF) wr_m[d][idx] = 1'b1;
      end else if (!w) begin
        rd_m[d] = oor ? 32'd0 : mem_m[d][idx];
      end
      check($sformatf("err_d%0d_a%h", d, a), {31'd0, er[d]}, {31'd0, oor});
      check($sformatf("read_data_d%0d_a%h", d, a), rd[d], rd_m[d]);
      check($sformatf("stall_ready_d%0d", d), {31'd0, stl[d]}, 32'd0);
    end
    if (!hold) req[d] = 1'b0;
  endtask

  task automatic model_reset();
    for (int d = 0; d < 3; d++) rd_m[d] = 32'd0;
  endtask

  initial begin
    req = '0; we = '0; be = '0; addr = '0; wd = '0;
    for (int d = 0; d < 3; d++)
      for (int i = 0; i < 256; i++) begin
        mem_m[d][i] = 32'd0;
        wr_m[d][i]  = 1'b0;
      end
    model_reset();

    // Reset asserted with a request pending.
    reset = 1'b1;
    req[0] = 1'b1; we[0] = 1'b1; be[0] = 4'hF; addr[0] = 32'h10; wd[0] = 32'h1;
    repeat (2) @(negedge clk);
    #1;
    check("rst_read_data", rd[0], 32'd0);
    check("rst_ready", {31'd0, rdy[0]}, 32'd0);
    check("rst_err", {31'd0, er[0]}, 32'd0);
    check("rst_stall", {31'd0, stl[0]}, 32'd0);
    req[0] = 1'b0;
    reset = 1'b0;

    // LATENCY=2 round trip.
    access(0, 1'b1, 4'hF, 32'h10, 32'hDEADBEEF, 0, 1'b0);
    access(0, 1'b0, 4'h0, 32'h10, 32'h0, 0, 1'b0);
    check("roundtrip_value", rd[0], 32'hDEADBEEF);

    // Byte enables.
    access(0, 1'b1, 4'hF, 32'h20, 32'h11223344, 0, 1'b0);
    access(0, 1'b1, 4'b0101, 32'h20, 32'hAABBCCDD, 0, 1'b0);
    access(0, 1'b0, 4'h0, 32'h20, 32'h0, 0, 1'b0);
    check("byte_en_value", rd[0], 32'h11BB33DD);

    // Out-of-range store must not alias onto word 0.
    access(0, 1'b1, 4'hF, 32'h0, 32'h0BADF00D, 0, 1'b0);
    access(0, 1'b1, 4'hF, 32'h400, 32'hFFFFFFFF, 0, 1'b0);
    access(0, 1'b0, 4'h0, 32'h400, 32'h0, 0, 1'b0);
    access(0, 1'b0, 4'h0, 32'h0, 32'h0, 0, 1'b0);
    check("oor_no_alias", rd[0], 32'h0BADF00D);
    access(0, 1'b0, 4'h0, 32'h23, 32'h0, 0, 1'b0);

    // Reset during WAIT discards the pending store.
    access(0, 1'b1, 4'hF, 32'h30, 32'h0, 0, 1'b0);
    @(negedge clk);
    req[0] = 1'b1; we[0] = 1'b1; be[0] = 4'hF; addr[0] = 32'h30; wd[0] = 32'h5555AAAA;
    @(negedge clk);
    reset = 1'b1;
    model_reset();
    #1;
    check("midrst_stall", {31'd0, stl[0]}, 32'd0);
    check("midrst_read_data", rd[0], 32'd0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("midrst_no_ready", {31'd0, rdy[0]}, 32'd0);
    end
    req[0] = 1'b0;
    reset = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("postrst_no_ready", {31'd0, rdy[0]}, 32'd0);
    end
    access(0, 1'b0, 4'h0, 32'h30, 32'h0, 0, 1'b0);
    check("midrst_value", rd[0], 32'h0);

    // LATENCY=0: back-to-back loads with req held high.
    access(1, 1'b1, 4'hF, 32'h40, 32'hCAFE0001, 0, 1'b0);
    access(1, 1'b1, 4'hF, 32'h44, 32'hCAFE0002, 0, 1'b0);
    access(1, 1'b1, 4'hF, 32'h48, 32'hCAFE0003, 0, 1'b0);
    access(1, 1'b0, 4'h0, 32'h40, 32'h0, 0, 1'b1);
    access(1, 1'b0, 4'h0, 32'h44, 32'h0, 0, 1'b1);
    access(1, 1'b0, 4'h0, 32'h48, 32'h0, 0, 1'b0);
    check("lat0_last_value", rd[1], 32'hCAFE0003);

    // LATENCY=4: req dropped during WAIT still completes, once.
    access(2, 1'b1, 4'hF, 32'h50, 32'h12345678, 2, 1'b0);
    @(negedge clk);
    #1;
    check("lat4_single_pulse", {31'd0, rdy[2]}, 32'd0);
    access(2, 1'b0, 4'h0, 32'h50, 32'h0, 0, 1'b0);
    check("lat4_value", rd[2], 32'h12345678);

    // Random accesses across all three instances.
    for (int n = 0; n < 40; n++) begin
      int          d;
      int          sel;
      bit          w;
      logic [3:0]  b;
      logic [31:0] a;
      d   = int'($urandom_range(0, 2));
      sel = int'($urandom_range(0, 5));
      w   = $urandom_range(0, 1) == 1;
      b   = 4'($urandom);
      if (sel == 0) a = $urandom | 32'h0000_0400;
      else a = (32'($urandom_range(0, 15)) << 2) | 32'($urandom_range(0, 3));
      if (sel != 0 && !wr_m[d][int'((a >> 2) & 32'hFF)]) begin
        w = 1'b1;
        b = 4'hF;
      end
      access(d, w, b, a, $urandom, 0, 1'b0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
